// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types, state encoding and motion helpers for sprite_player.
package sprite_pkg;

    localparam int SPR_COORD_W = 19;
    localparam int RGB_W       = 24;

    typedef logic [RGB_W-1:0]       rgb_t;
    typedef logic [SPR_COORD_W-1:0] coord_t;

    localparam rgb_t RGB_BLACK = '0;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    // Speed and hold counter of one axis after an accelerating tick
    typedef struct packed {
        logic [31:0] spd;
        logic [31:0] hold;
    } accel_t;

    // One tick with exactly one direction held: start at speed 1, then ramp
    // by one every accel_ticks held ticks, saturating at max_spd.
    function automatic accel_t accel_step(input logic [31:0] spd,
                                          input logic [31:0] hold,
                                          input int unsigned accel_ticks,
                                          input int unsigned max_spd);
        accel_t r;
        r.spd  = spd;
        r.hold = hold;
        if (spd == 32'd0) begin
            r.spd = 32'd1;
        end else begin
            r.hold = hold + 32'd1;
            if (r.hold >= accel_ticks) begin
                r.hold = 32'd0;
                if (spd < max_spd)
                    r.spd = spd + 32'd1;
            end
        end
        return r;
    endfunction

    // Move by step and wrap into [0, span); span is a power of two
    function automatic logic [31:0] wrap_step(input logic [31:0] pos,
                                              input logic [31:0] step,
                                              input logic        neg,
                                              input logic [31:0] span);
        logic [31:0] r;
        r = neg ? (pos - step) : (pos + step);
        return r & (span - 32'd1);
    endfunction

    // Move by step and clamp into [0, hi]
    function automatic logic [31:0] clamp_step(input logic [31:0] pos,
                                               input logic [31:0] step,
                                               input logic        neg,
                                               input logic [31:0] hi);
        logic [31:0] r;
        if (neg)
            r = (step > pos) ? 32'd0 : (pos - step);
        else
            r = ((pos + step) > hi) ? hi : (pos + step);
        return r;
    endfunction

endpackage

// File: rtl/sprite_delay_line.sv
// sprite_delay_line: DEPTH x WIDTH shift register on the falling clock edge,
// cleared by reset so no stale pixel qualifiers survive a reset.
module sprite_delay_line
    import sprite_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock
    always_ff @(negedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_player.sv
// sprite_player: button-driven player sprite with tick-divided motion,
// hold-to-accelerate speed, horizontal wrap and vertical clamp. The pixel
// path reads only the frame-synchronous shadow position and returns a pixel
// aligned to the external image ROM latency (ROM_LAT+2 clocks from x/y).
// Build macro SPRITE_COLORKEY_EN: hit pixels equal to KEY_RGB render black.
//
// state | meaning
// IDLE  | start low: tick, speed and hold counters held at 0, position frozen
// PLAY  | start high: each motion tick updates speed and position
//
// All state updates on the falling edge of clock_i.
module sprite_player
    import sprite_pkg::*;
#(
    parameter int COORD_W     = 19,
    parameter int SPR_W       = 30,
    parameter int SPR_H       = 40,
    parameter int WRAP_W      = 512,
    parameter int SCREEN_H    = 480,
    parameter int INIT_X      = 320,
    parameter int INIT_Y      = 400,
    parameter int TICK_DIV    = 100000,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int ROM_LAT     = 1,
    parameter int ADDR_W      = $clog2(SPR_W * SPR_H)
`ifdef SPRITE_COLORKEY_EN
    ,
    parameter logic [23:0] KEY_RGB = 24'hFF00FF
`endif
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               frame_start_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic               left_i,
    input  logic               right_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [COORD_W-1:0] ship_x_o,
    output logic [COORD_W-1:0] ship_y_o,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [23:0]        rom_q_i,
    output logic [23:0]        rgb_o
);

    localparam int SPD_W  = $clog2(MAX_SPEED + 1);
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int Y_MAX  = SCREEN_H - SPR_H;

    logic [0:0]         mode;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               tick;
    logic [SPD_W-1:0]   spd_x_q, spd_x_d, spd_y_q, spd_y_d;
    logic [HOLD_W-1:0]  hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    logic [COORD_W-1:0] ship_x_q, ship_x_d, ship_y_q, ship_y_d;
    logic [COORD_W-1:0] disp_x_q, disp_y_q;
    accel_t             acc_x, acc_y;
    logic [31:0]        y_new;
    logic               move_x, move_y;

    logic [COORD_W-1:0] dx, dy;
    logic               hit;
    logic [ADDR_W-1:0]  addr_d, rom_addr_q;
    logic               hit_al, start_al, pix_on;
    rgb_t               rgb_q;

    // Buttons are active low: an axis moves only when its two buttons differ
    assign move_x = left_i ^ right_i;
    assign move_y = up_i ^ down_i;
    assign mode   = start_i ? PLAY : IDLE;
    assign tick   = (tick_q == TICK_W'(TICK_DIV - 1));

    // Next-state for the tick timer, per-axis speed/hold and ship position
    always_comb begin
        tick_d   = tick_q;
        spd_x_d  = spd_x_q;
        hold_x_d = hold_x_q;
        spd_y_d  = spd_y_q;
        hold_y_d = hold_y_q;
        ship_x_d = ship_x_q;
        ship_y_d = ship_y_q;
        acc_x    = accel_step(32'(spd_x_q), 32'(hold_x_q), ACCEL_TICKS, MAX_SPEED);
        acc_y    = accel_step(32'(spd_y_q), 32'(hold_y_q), ACCEL_TICKS, MAX_SPEED);
        y_new    = clamp_step(32'(ship_y_q), acc_y.spd, ~up_i, 32'(Y_MAX));
        if (mode == IDLE) begin
            tick_d   = '0;
            spd_x_d  = '0;
            hold_x_d = '0;
            spd_y_d  = '0;
            hold_y_d = '0;
        end else begin
            tick_d = tick ? '0 : tick_q + TICK_W'(1);
            if (tick) begin
                if (move_x) begin
                    spd_x_d  = SPD_W'(acc_x.spd);
                    hold_x_d = HOLD_W'(acc_x.hold);
                    ship_x_d = COORD_W'(wrap_step(32'(ship_x_q), acc_x.spd, ~left_i,
                                                  32'(WRAP_W)));
                end else begin
                    spd_x_d  = '0;
                    hold_x_d = '0;
                end
                if (move_y) begin
                    ship_y_d = COORD_W'(y_new);
                    // Hitting either clamp limit stops the axis dead
                    if ((!up_i && y_new == 32'd0) || (!down_i && y_new == 32'(Y_MAX))) begin
                        spd_y_d  = '0;
                        hold_y_d = '0;
                    end else begin
                        spd_y_d  = SPD_W'(acc_y.spd);
                        hold_y_d = HOLD_W'(acc_y.hold);
                    end
                end else begin
                    spd_y_d  = '0;
                    hold_y_d = '0;
                end
            end
        end
    end

    // Motion registers; the shadow takes the pre-tick position on a shared edge
    always_ff @(negedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tick_q   <= '0;
            spd_x_q  <= '0;
            hold_x_q <= '0;
            spd_y_q  <= '0;
            hold_y_q <= '0;
            ship_x_q <= COORD_W'(INIT_X);
            ship_y_q <= COORD_W'(INIT_Y);
            disp_x_q <= COORD_W'(INIT_X);
            disp_y_q <= COORD_W'(INIT_Y);
        end else begin
            tick_q   <= tick_d;
            spd_x_q  <= spd_x_d;
            hold_x_q <= hold_x_d;
            spd_y_q  <= spd_y_d;
            hold_y_q <= hold_y_d;
            ship_x_q <= ship_x_d;
            ship_y_q <= ship_y_d;
            if (frame_start_i) begin
                disp_x_q <= ship_x_q;
                disp_y_q <= ship_y_q;
            end
        end
    end

    // Sprite-relative offsets; a scan line above the sprite wraps dy large
    always_comb begin
        dx     = (x_i - disp_x_q) & COORD_W'(WRAP_W - 1);
        dy     = y_i - disp_y_q;
        hit    = (dx < COORD_W'(SPR_W)) && (dy < COORD_W'(SPR_H));
        addr_d = hit ? ADDR_W'(32'(dy) * 32'(SPR_W) + 32'(dx)) : '0;
    end

    // Carry hit and start alongside the ROM read so they meet rom_q
    sprite_delay_line #(
        .DEPTH (ROM_LAT + 1),
        .WIDTH (2)
    ) u_align (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     ({hit, start_i}),
        .q_o     ({hit_al, start_al})
    );

`ifdef SPRITE_COLORKEY_EN
    assign pix_on = hit_al && start_al && (rom_q_i != KEY_RGB);
`else
    assign pix_on = hit_al && start_al;
`endif

    // Registered ROM address and output pixel
    always_ff @(negedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rom_addr_q <= '0;
            rgb_q      <= RGB_BLACK;
        end else begin
            rom_addr_q <= addr_d;
            rgb_q      <= pix_on ? rgb_t'(rom_q_i) : RGB_BLACK;
        end
    end

    assign ship_x_o   = ship_x_q;
    assign ship_y_o   = ship_y_q;
    assign rom_addr_o = rom_addr_q;
    assign rgb_o      = rgb_q;

endmodule

// File: tb/tb_sprite_player.sv
// tb_sprite_player: directed bench for sprite_player with a small tick divider
// and a two-clock image ROM model. Honours SPRITE_COLORKEY_EN when defined.
module tb_sprite_player;

    localparam int TD = 4;
    localparam int CW = 19;
    localparam int AW = 11;

`ifdef SPRITE_COLORKEY_EN
    localparam logic [23:0] KEY_PIX_EXP = 24'h000000;
`else
    localparam logic [23:0] KEY_PIX_EXP = 24'hFF00FF;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b1;
    logic          frame_start = 1'b0;
    logic [CW-1:0] x = '0;
    logic [CW-1:0] y = '0;
    logic          left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic [CW-1:0] ship_x, ship_y;
    logic [AW-1:0] rom_addr;
    logic [AW-1:0] rom_p1 = '0;
    logic [23:0]   rom_q = '0;
    logic [23:0]   rgb;

    int n_checks = 0;
    int n_fail   = 0;
    int negs     = 0;

    sprite_player #(
        .TICK_DIV (TD),
        .ROM_LAT  (2)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .start_i       (start),
        .frame_start_i (frame_start),
        .x_i           (x),
        .y_i           (y),
        .left_i        (left),
        .right_i       (right),
        .up_i          (up),
        .down_i        (down),
        .ship_x_o      (ship_x),
        .ship_y_o      (ship_y),
        .rom_addr_o    (rom_addr),
        .rom_q_i       (rom_q),
        .rgb_o         (rgb)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] rom_fn(input logic [AW-1:0] a);
        if (a == AW'(5)) return 24'hFF00FF;
        if (a == AW'(6)) return 24'h123456;
        return 24'h100000 | 24'(a);
    endfunction

    // Image ROM with two clocks of read latency, same edge as the DUT
    always @(negedge clock) begin
        rom_p1 <= rom_addr;
        rom_q  <= rom_fn(rom_p1);
    end

    always @(negedge clock) begin
        if (reset) negs <= 0;
        else       negs <= negs + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to the rising edge just after the next motion tick
    task automatic align();
        do @(posedge clock); while (negs % TD != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n * TD) @(posedge clock);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clock);
        frame_start = 1'b0;
        @(posedge clock);
    endtask

    // One-clock pixel between misses: address after 1 clock, pixel after exactly 4
    task automatic probe(input string tag, input int px, input int py,
                         input int exp_addr, input logic [23:0] exp_rgb);
        x = '0; y = '0;
        repeat (4) @(posedge clock);
        x = CW'(px); y = CW'(py);
        @(posedge clock);
        check_eq({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        x = '0; y = '0;
        repeat (2) @(posedge clock);
        check_eq({tag, "_early"}, 32'(rgb), 32'h0);
        @(posedge clock);
        check_eq({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
        @(posedge clock);
        check_eq({tag, "_late"}, 32'(rgb), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        check_eq("rst_ship_x", 32'(ship_x), 32'd320);
        check_eq("rst_ship_y", 32'(ship_y), 32'd400);
        check_eq("rst_rgb", 32'(rgb), 32'h0);
        check_eq("rst_addr", 32'(rom_addr), 32'h0);

        reset = 1'b0; left = 1'b0; right = 1'b1; up = 1'b1; down = 1'b1;
        repeat (TD - 1) @(posedge clock);
        check_eq("no_early_tick", 32'(ship_x), 32'd320);
        @(posedge clock);
        check_eq("first_tick", 32'(ship_x), 32'd319);
        check_eq("y_static", 32'(ship_y), 32'd400);
        ticks(7);
        check_eq("left_8", 32'(ship_x), 32'd312);
        ticks(8);
        check_eq("left_16", 32'(ship_x), 32'd296);
        ticks(4);
        check_eq("left_20", 32'(ship_x), 32'd284);

        left = 1'b1;
        ticks(1);
        check_eq("release_nomove", 32'(ship_x), 32'd284);
        right = 1'b0;
        ticks(1);
        check_eq("speed_restart", 32'(ship_x), 32'd285);
        right = 1'b1;

        probe("pix_lat", 323, 402, 63, 24'h10003F);
        probe("pix_corner", 349, 439, 1199, 24'h1004AF);
        probe("pix_dx30", 350, 400, 0, 24'h0);
        probe("pix_above", 320, 399, 0, 24'h0);

        pulse_frame();
        probe("shadow_load", 288, 401, 33, 24'h100021);

        align();
        left = 1'b0;
        ticks(83);
        check_eq("x_ramp", 32'(ship_x), 32'd1);
        left = 1'b1;
        ticks(1);
        left = 1'b0;
        ticks(1);
        check_eq("x_to_zero", 32'(ship_x), 32'd0);
        ticks(1);
        check_eq("x_wrap_left", 32'(ship_x), 32'd511);
        left = 1'b1; right = 1'b0;
        ticks(1);
        check_eq("x_wrap_right", 32'(ship_x), 32'd0);
        right = 1'b1;
        ticks(1);
        left = 1'b0;
        ticks(10);
        check_eq("x_to_500", 32'(ship_x), 32'd500);
        left = 1'b1;

        pulse_frame();
        probe("wrap_hit", 5, 400, 17, 24'h100011);
        probe("wrap_miss", 25, 400, 0, 24'h0);

        align();
        down = 1'b0; left = 1'b0; right = 1'b0;
        ticks(21);
        check_eq("y_ramp", 32'(ship_y), 32'd439);
        ticks(1);
        check_eq("y_clamp", 32'(ship_y), 32'd440);
        check_eq("x_opposed", 32'(ship_x), 32'd500);
        down = 1'b1; up = 1'b0; left = 1'b1; right = 1'b1;
        ticks(1);
        check_eq("y_speed_cleared", 32'(ship_y), 32'd439);

        repeat (TD - 1) @(posedge clock);
        frame_start = 1'b1;
        @(posedge clock);
        frame_start = 1'b0;
        check_eq("y_same_edge_tick", 32'(ship_y), 32'd438);
        up = 1'b1;
        probe("shadow_pretick", 501, 439, 1, 24'h100001);

        probe("key_pix", 505, 439, 5, KEY_PIX_EXP);
        probe("nonkey_pix", 506, 439, 6, 24'h123456);

        start = 1'b0; left = 1'b0;
        ticks(3);
        check_eq("idle_frozen", 32'(ship_x), 32'd500);
        left = 1'b1;
        probe("idle_black", 501, 439, 1, 24'h0);

        start = 1'b1;
        x = CW'(501); y = CW'(439);
        repeat (5) @(posedge clock);
        check_eq("steady_hit", 32'(rgb), 32'h100001);
        reset = 1'b1;
        #1;
        check_eq("reset_rgb", 32'(rgb), 32'h0);
        check_eq("reset_ship_x", 32'(ship_x), 32'd320);
        check_eq("reset_ship_y", 32'(ship_y), 32'd400);
        @(posedge clock);
        x = CW'(323); y = CW'(402);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        check_eq("reset_flush", 32'(rgb), 32'h0);
        @(posedge clock);
        check_eq("reset_refill", 32'(rgb), 32'h10003F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
